// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU operand-buffer loader.
//   MMU_SIZE   : tile edge in elements
//   BUFFER_CNT : tiles per operand buffer
//   ADDR_W     : operand buffer address width
//   BUFFER_A/B : buf_sel codes
//   loader_state_e : loader FSM states
package mpu_pkg;

  localparam int MMU_SIZE   = 10;
  localparam int BUFFER_CNT = 4;
  localparam int ADDR_W     = 9;
  localparam int IDX_W      = 5;
  localparam int DIM_W      = 8;

  localparam logic BUFFER_A = 1'b0;
  localparam logic BUFFER_B = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } loader_state_e;

endpackage

// File: rtl/mpu_tile_walker.sv
// Row-major cell walker for one MMU_SIZE x MMU_SIZE tile.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start_i           : reset row/col to 0 and load base_i as running address
//   base_i            : first buffer address of the tile
//   step_i            : advance to the next cell
//   dim_x_i, dim_y_i  : matrix columns / rows (cells outside are padding)
//   addr_o            : buffer address of the current cell
//   data_cell_o       : current cell lies inside the matrix
//   last_cell_o       : current cell is (MMU_SIZE-1, MMU_SIZE-1)
module mpu_tile_walker import mpu_pkg::*; #(
  parameter int MMU_SIZE = mpu_pkg::MMU_SIZE,
  parameter int ADDR_W   = mpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              step_i,
  input  logic [DIM_W-1:0]  dim_x_i,
  input  logic [DIM_W-1:0]  dim_y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              data_cell_o,
  output logic              last_cell_o
);

  localparam int CNT_W = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MMU_SIZE - 1);

  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // The running address is simply incremented: row-major order within a
  // tile makes base + row*MMU_SIZE + col equal to base + cells walked.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (start_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = base_i;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o      = addr_q;
  assign data_cell_o = (DIM_W'(row_q) < dim_y_i) && (DIM_W'(col_q) < dim_x_i);
  assign last_cell_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/mpu_buffer_loader.sv
// Lays a dim_y x dim_x matrix from the frame decoder out as a full
// MMU_SIZE x MMU_SIZE tile in operand buffer A or B, zero-padding the
// cells outside the matrix. in_ready drops while padding so the decoder
// stalls until the next data cell.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load_i                : start pulse, latches buf_sel/idx/dims
//   buf_sel_i             : 0 = buffer A, 1 = buffer B
//   idx_a_i, idx_b_i      : target tile index for buffer A / B
//   dim_x_i, dim_y_i      : matrix columns / rows
//   data_in_i, data_valid_i : operand byte stream
//   abort_i               : cancel the current fill
//   in_ready_o            : data_in accepted this cycle
//   mem_we_a_o, mem_we_b_o, mem_addr_o, mem_wdata_o : registered write port
//   busy_o                : tile fill in progress
//   done_o                : pulse with the final tile write
//   load_err_o            : pulse after a rejected load or an abort
module mpu_buffer_loader import mpu_pkg::*; #(
  parameter int MMU_SIZE   = mpu_pkg::MMU_SIZE,
  parameter int BUFFER_CNT = mpu_pkg::BUFFER_CNT,
  parameter int ADDR_W     = mpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              buf_sel_i,
  input  logic [IDX_W-1:0]  idx_a_i,
  input  logic [IDX_W-1:0]  idx_b_i,
  input  logic [DIM_W-1:0]  dim_x_i,
  input  logic [DIM_W-1:0]  dim_y_i,
  input  logic [7:0]        data_in_i,
  input  logic              data_valid_i,
  input  logic              abort_i,
  output logic              in_ready_o,
  output logic              mem_we_a_o,
  output logic              mem_we_b_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              load_err_o
);

  localparam int TILE_CELLS = MMU_SIZE * MMU_SIZE;

  loader_state_e     state_q;
  logic              sel_q;
  logic [DIM_W-1:0]  dim_x_q;
  logic [DIM_W-1:0]  dim_y_q;
  logic              mem_we_a_q;
  logic              mem_we_b_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              load_err_q;

  logic [IDX_W-1:0]  idx_sel;
  logic              cfg_ok;
  logic              start;
  logic              cell_issue;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] walk_addr;
  logic              data_cell;
  logic              last_cell;

  always_comb begin
    idx_sel = (buf_sel_i == BUFFER_B) ? idx_b_i : idx_a_i;
    cfg_ok  = (int'(dim_x_i) <= MMU_SIZE) && (int'(dim_y_i) <= MMU_SIZE) &&
              (int'(idx_sel) < BUFFER_CNT);
    start   = (state_q == ST_IDLE) && load_i && cfg_ok;
    // Only evaluated on an accepted load; the walk itself just increments.
    base    = ADDR_W'(int'(idx_sel) * TILE_CELLS);
    // Pad cells always issue; data cells wait for a valid byte.
    cell_issue = (state_q == ST_FILL) && !abort_i && (!data_cell || data_valid_i);
  end

  mpu_tile_walker #(
    .MMU_SIZE (MMU_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_walker (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_i      (base),
    .step_i      (cell_issue),
    .dim_x_i     (dim_x_q),
    .dim_y_i     (dim_y_q),
    .addr_o      (walk_addr),
    .data_cell_o (data_cell),
    .last_cell_o (last_cell)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= BUFFER_A;
      dim_x_q     <= '0;
      dim_y_q     <= '0;
      mem_we_a_q  <= 1'b0;
      mem_we_b_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mem_we_a_q <= 1'b0;
      mem_we_b_q <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        // busy_q stays high through the done cycle and clears here.
        busy_q <= 1'b0;
        if (load_i) begin
          if (cfg_ok) begin
            state_q <= ST_FILL;
            sel_q   <= buf_sel_i;
            dim_x_q <= dim_x_i;
            dim_y_q <= dim_y_i;
            busy_q  <= 1'b1;
          end else begin
            load_err_q <= 1'b1;
          end
        end
      end else begin
        if (abort_i) begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          load_err_q <= 1'b1;
        end else begin
          if (load_i) begin
            load_err_q <= 1'b1;
          end
          if (cell_issue) begin
            mem_we_a_q  <= (sel_q == BUFFER_A);
            mem_we_b_q  <= (sel_q == BUFFER_B);
            mem_addr_q  <= walk_addr;
            mem_wdata_q <= data_cell ? data_in_i : 8'h00;
            if (last_cell) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE) || data_cell;
  assign mem_we_a_o  = mem_we_a_q;
  assign mem_we_b_o  = mem_we_b_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  // busy falls in the very cycle abort is seen, not one cycle later.
  assign busy_o      = busy_q && !((state_q == ST_FILL) && abort_i);
  assign done_o      = done_q;
  assign load_err_o  = load_err_q;

endmodule

// File: doc/mpu_buffer_loader.md
# mpu_buffer_loader

Writes matrix operands from the raw-Ethernet frame decoder into the MPU operand buffers. It sits directly downstream of the decoder's load outputs (`load`, buffer select, indices, `dim_x`/`dim_y`, data bytes). It lays each received dim_y × dim_x matrix out as a full MMU_SIZE × MMU_SIZE tile, zero-padding unused cells. While padding it deasserts `in_ready`, which the top level ANDs into the decoder's `mpu_ready`.

## Interface
- MMU_SIZE, 10, tile edge in elements
- BUFFER_CNT, 4, tiles per operand buffer
- ADDR_W, 9, buffer address width; must satisfy 2^ADDR_W ≥ BUFFER_CNT·MMU_SIZE²
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- load  in  1  one-cycle start pulse; latches all configuration inputs below
- buf_sel  in  1  0 = buffer A, 1 = buffer B
- idx_a  in  5  target tile index when buf_sel = 0
- idx_b  in  5  target tile index when buf_sel = 1
- dim_x  in  8  row length (columns)
- dim_y  in  8  column length (rows)
- data_in  in  8  operand byte
- data_valid  in  1  data_in carries a frame byte this cycle
- abort  in  1  decoder entered its error state or the frame ended early
- in_ready  out  1  loader accepts data_in this cycle
- mem_we_a  out  1  write strobe, buffer A
- mem_we_b  out  1  write strobe, buffer B
- mem_addr  out  ADDR_W  write address = idx·MMU_SIZE² + row·MMU_SIZE + col
- mem_wdata  out  8  write data
- busy  out  1  tile fill in progress
- done  out  1  one-cycle pulse on the final tile write
- load_err  out  1  one-cycle pulse on a rejected load or an aborted fill

## Operation
- States:
  - IDLE: in_ready = 1; incoming bytes are discarded.
  - FILL: walks cells (row, col) in row-major order, 0..MMU_SIZE-1 each.
- IDLE → FILL on `load` only when all of these hold; otherwise stay IDLE and pulse load_err:
  - dim_x ≤ MMU_SIZE
  - dim_y ≤ MMU_SIZE
  - selected idx < BUFFER_CNT
- On the accepted load, latch sel, idx, dims; set row = col = 0; set base = idx·MMU_SIZE².
- Per cycle in FILL:
  - Cell is a data cell when row < dim_y and col < dim_x.
  - Data cell: in_ready = 1. If data_valid, issue a write of data_in and advance. Otherwise hold the cell and write nothing.
  - Pad cell: in_ready = 0. Issue a write of 8'h00 and advance, independent of data_valid.
- Advance: col+1, or col = 0 and row+1 at MMU_SIZE-1; running address +1. No multiplier inside the walk.
- After cell (MMU_SIZE-1, MMU_SIZE-1) is issued, return to IDLE. Every accepted load produces exactly MMU_SIZE² writes.
- dim_x = 0 or dim_y = 0: the whole tile is zero-filled.
- abort in FILL: return to IDLE immediately, issue no write that cycle, pulse load_err, no done. Cells already written stay written.
- abort in IDLE: ignored.
- load in FILL: ignored, pulse load_err; the current fill continues.
- Bytes after the last data cell (Ethernet minimum-length padding) arrive in pad cells or in IDLE and are discarded.

## Timing
- Reset values: in_ready 1, mem_we_a/b 0, mem_addr 0, mem_wdata 0, busy 0, done 0, load_err 0; state IDLE.
- load in cycle N: FILL from N+1. in_ready reflects the cell type combinationally from N+1.
- A write decided in cycle k appears registered in k+1: mem_we_x, mem_addr, mem_wdata.
- done is high in the same cycle as the last mem_we.
- busy is high from N+1 through the done cycle inclusive; it drops in the cycle an abort is seen.
- Minimum fill time with data_valid held high: MMU_SIZE² cycles plus 1 cycle output latency.
- load_err is registered: it appears one cycle after the offending load or abort.

## Structure
- Shared package mpu_pkg: MMU_SIZE, BUFFER_CNT, BUFFER_A/BUFFER_B select codes, loader state enum.
- One sub-module, mpu_tile_walker: the row/col/address counter with a step input, the data-cell flag, and a last-cell flag.

## Test plan
- **Full tile:** load, buf_sel = 0, idx_a = 1, dims 10×10, 100 bytes 1..100 with data_valid held high → 100 writes on mem_we_a at addr 100..199, data 1..100; done with the last write; in_ready never low.
- **Padding:** dims 3×2, idx_b = 0, buf_sel = 1, bytes AA, BB, CC, DD, EE, FF → mem_we_b:
  - addr 0..2 = AA, BB, CC
  - addr 3..9 = 0
  - addr 10..12 = DD, EE, FF
  - addr 13..99 = 0
  - in_ready low during addr 3..9 and from addr 13 onward.
- **Gaps:** 10×10 with data_valid toggling 1010… → 100 writes, stable addressing, no writes on invalid cycles.
- **Rejection:** dim_x = 11 → load_err pulse, no writes, busy stays 0. Load with idx_a = 4 → same response.
- **Abort:** abort after 37 data bytes of a 10×10 load → 37 writes total, busy drops, load_err pulse, no done; a following load works normally.
- **Reset mid-fill:** rst_n low at write 50 → all outputs return to reset values on the next edge; a later load starts again at row 0, col 0.
